// File: rtl/pxs_ball_ctrl_pkg.sv
// Package shared by the ball controller files.
// Contents:
//   - pixel-stream field positions;
//   - the FSM state type;
//   - helpers to pick the column/row counters out of a stream word and to build one.
// Stream layout: XC = [25:16], YC = [15:6], RGB = [5:0].
package pxs_ball_ctrl_pkg;

    localparam int unsigned STR_W  = 26;
    localparam int unsigned CRD_W  = 10;
    localparam int unsigned XC_LSB = 16;
    localparam int unsigned YC_LSB = 6;
    localparam int unsigned RGB_W  = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPEED,
        S_BOUNCE,
        S_MOVE
    } state_t;

    function automatic logic [CRD_W-1:0] str_xc(input logic [STR_W-1:0] s);
        return s[XC_LSB +: CRD_W];
    endfunction

    function automatic logic [CRD_W-1:0] str_yc(input logic [STR_W-1:0] s);
        return s[YC_LSB +: CRD_W];
    endfunction

    function automatic logic [STR_W-1:0] mk_stream(input logic [CRD_W-1:0] xc,
                                                   input logic [CRD_W-1:0] yc);
        logic [STR_W-1:0] s;
        s = '0;
        s[XC_LSB +: CRD_W] = xc;
        s[YC_LSB +: CRD_W] = yc;
        return s;
    endfunction

endpackage

// File: rtl/pxs_edge_detect.sv
// Registered 1-bit rising-edge detector with synchronous active-high reset.
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous reset, active high
//   i_level - input level (already debounced)
//   o_rise  - one-cycle pulse, the cycle after a 0->1 transition was sampled
module pxs_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_prev <= i_level;
            o_rise <= i_level & ~r_prev;
        end
    end

endmodule

// File: rtl/pxs_ball_ctrl.sv
// Frame-synchronous bouncing-ball motion controller.
// At end of frame it runs S_SPEED -> S_BOUNCE -> S_MOVE, one cycle each, then returns to idle.
// Ports:
//   px_clk, rst          - pixel clock, synchronous active-high reset
//   RGBStr_i             - pixel stream; only XC/YC are used, to detect end of frame
//   inc_vel, dec_vel     - button levels; each rising edge queues a speed +1 / -1 request
//   pause                - while high, end-of-frame updates are skipped
//   x_ball, y_ball       - ball top-left coordinate
//   speed                - px/frame
//   bounce_x, bounce_y   - one-cycle bounce pulses
//   busy                 - high while the update sequence is running
module pxs_ball_ctrl
    import pxs_ball_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_BALL   = 16,
    parameter int unsigned VISIBLECOLS = 640,
    parameter int unsigned VISIBLEROWS = 480,
    parameter int unsigned SPEED_INIT  = 1,
    parameter int unsigned SPEED_MAX   = 20
) (
    input  logic             px_clk,
    input  logic             rst,
    input  logic [STR_W-1:0] RGBStr_i,
    input  logic             inc_vel,
    input  logic             dec_vel,
    input  logic             pause,
    output logic [9:0]       x_ball,
    output logic [9:0]       y_ball,
    output logic [4:0]       speed,
    output logic             bounce_x,
    output logic             bounce_y,
    output logic             busy
);

    localparam logic [10:0] X_MAX   = 11'(VISIBLECOLS - SIZE_BALL);
    localparam logic [10:0] Y_MAX   = 11'(VISIBLEROWS - SIZE_BALL);
    localparam logic [9:0]  X_MAX10 = 10'(VISIBLECOLS - SIZE_BALL);
    localparam logic [9:0]  Y_MAX10 = 10'(VISIBLEROWS - SIZE_BALL);
    localparam logic [9:0]  X_RST   = 10'((VISIBLECOLS - SIZE_BALL) / 4);
    localparam logic [9:0]  Y_RST   = 10'((VISIBLEROWS - SIZE_BALL) / 2);
    localparam logic [9:0]  EOF_X   = 10'(VISIBLECOLS - 1);
    localparam logic [9:0]  EOF_Y   = 10'(VISIBLEROWS - 1);
    localparam logic [4:0]  SPD_RST = 5'(SPEED_INIT);
    localparam logic [4:0]  SPD_MAX = 5'(SPEED_MAX);

    state_t      r_state;
    logic        r_dx;          // 0: x increasing
    logic        r_dy;          // 0: y increasing
    logic        r_pend_inc;
    logic        r_pend_dec;
    logic        w_inc_rise;
    logic        w_dec_rise;
    logic        w_endframe;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic [9:0]  w_speed10;

    pxs_edge_detect u_inc_edge (
        .i_clk   (px_clk),
        .i_rst   (rst),
        .i_level (inc_vel),
        .o_rise  (w_inc_rise)
    );

    pxs_edge_detect u_dec_edge (
        .i_clk   (px_clk),
        .i_rst   (rst),
        .i_level (dec_vel),
        .o_rise  (w_dec_rise)
    );

    assign w_endframe = (str_xc(RGBStr_i) == EOF_X) && (str_yc(RGBStr_i) == EOF_Y);
    assign w_speed10  = {5'b0, speed};
    // One extra bit so the sum cannot wrap before it is clamped to the wall.
    assign w_x_sum    = {1'b0, x_ball} + {1'b0, w_speed10};
    assign w_y_sum    = {1'b0, y_ball} + {1'b0, w_speed10};

    always_ff @(posedge px_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dx       <= 1'b0;
            r_dy       <= 1'b0;
            r_pend_inc <= 1'b0;
            r_pend_dec <= 1'b0;
            x_ball     <= X_RST;
            y_ball     <= Y_RST;
            speed      <= SPD_RST;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            r_pend_inc <= r_pend_inc | w_inc_rise;
            r_pend_dec <= r_pend_dec | w_dec_rise;
            unique case (r_state)
                S_IDLE: begin
                    if (w_endframe && !pause) begin
                        r_state <= S_SPEED;
                        busy    <= 1'b1;
                    end
                end
                S_SPEED: begin
                    if (r_pend_inc && !r_pend_dec) begin
                        speed <= (speed >= SPD_MAX) ? SPD_MAX : speed + 5'd1;
                    end else if (r_pend_dec && !r_pend_inc) begin
                        speed <= (speed == 5'd0) ? 5'd0 : speed - 5'd1;
                    end
                    // A request edge landing in this very cycle survives to the next frame.
                    r_pend_inc <= w_inc_rise;
                    r_pend_dec <= w_dec_rise;
                    r_state    <= S_BOUNCE;
                end
                S_BOUNCE: begin
                    if ((!r_dx && ({1'b0, x_ball} >= X_MAX)) || (r_dx && (x_ball == 10'd0))) begin
                        r_dx     <= ~r_dx;
                        bounce_x <= 1'b1;
                    end
                    if ((!r_dy && ({1'b0, y_ball} >= Y_MAX)) || (r_dy && (y_ball == 10'd0))) begin
                        r_dy     <= ~r_dy;
                        bounce_y <= 1'b1;
                    end
                    r_state <= S_MOVE;
                end
                S_MOVE: begin
                    if (!r_dx) begin
                        x_ball <= (w_x_sum > X_MAX) ? X_MAX10 : w_x_sum[9:0];
                    end else begin
                        x_ball <= (x_ball < w_speed10) ? 10'd0 : x_ball - w_speed10;
                    end
                    if (!r_dy) begin
                        y_ball <= (w_y_sum > Y_MAX) ? Y_MAX10 : w_y_sum[9:0];
                    end else begin
                        y_ball <= (y_ball < w_speed10) ? 10'd0 : y_ball - w_speed10;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
